// File: rtl/multicycle_adder.sv
// multicycle_adder: adds or subtracts two WIDTH-bit operands CHUNK bits per clock.
//
// Parameters
//   WIDTH     operand/result width in bits; must be an integer multiple of CHUNK
//   CHUNK     bits summed per CALC cycle (NCH = WIDTH/CHUNK cycles per operation)
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   in_valid  operand set valid            in_ready   accepting operands (IDLE only)
//   in1, in2  operands                     sub        0: in1+in2, 1: in1-in2
//   out_valid result valid (DONE only)     out_ready  consumer takes the result
//   out       result modulo 2^WIDTH
//   carry_out carry out of the MSB (for subtraction, 1 = no borrow)
//   overflow  two's-complement signed overflow
module multicycle_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned NCH   = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;      // already inverted for subtraction
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] res_q, res_d;  // accumulates the result chunk by chunk
    logic [WIDTH-1:0] out_q, out_d;  // published result, held until the next completion
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    int unsigned      base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum;
    logic             msb_cin;

    // Chunk datapath: one CHUNK-bit ripple slice reused every CALC cycle.
    always_comb begin
        base    = 32'(idx_q) * CHUNK;
        a_chunk = a_q[base +: CHUNK];
        b_chunk = b_q[base +: CHUNK];
        sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of this chunk, recovered from the sum bit.
        msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum[CHUNK-1];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        res_d   = res_q;
        out_d   = out_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Subtraction is in1 + ~in2 + 1; the +1 enters as the initial carry.
                    a_d     = in1;
                    b_d     = sub ? ~in2 : in2;
                    carry_d = sub;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                res_d[base +: CHUNK] = sum[CHUNK-1:0];
                carry_d              = sum[CHUNK];
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    out_d   = res_d;
                    cout_d  = sum[CHUNK];
                    ovf_d   = msb_cin ^ sum[CHUNK];
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out       = out_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule
